// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and constants.
// Used by the instruction tag controller slice.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_WIDHT      = 20;
  localparam int TAG_ADDR_WIDHT = 6;
  localparam int RR_W           = $clog2(ICACHE_N_WAY);

  typedef enum logic [1:0] {
    IDLE,
    LKP_RSP,
    RFL_WR,
    FLUSH
  } itag_state_t;

  typedef logic [ICACHE_N_WAY-1:0]   way_oh_t;
  typedef logic [TAG_WIDHT-1:0]      tag_t;
  typedef logic [TAG_ADDR_WIDHT-1:0] set_t;
  typedef logic [RR_W-1:0]           rr_t;

  // Isolate the lowest set bit of a way vector.
  function automatic way_oh_t lowest_one(way_oh_t v);
    return v & (~v + way_oh_t'(1));
  endfunction

  // True when two or more bits are set.
  function automatic logic more_than_one(way_oh_t v);
    return (v & (v - way_oh_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// Tag memory port bundle.
// master = controller side, slave = memory side.
interface sargantana_itag_ctrl_if;
  import sargantana_icache_pkg::*;

  way_oh_t                           req;
  logic                              we;
  logic                              vbit;
  logic                              flush;
  tag_t                              data;
  set_t                              addr;
  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] rd_tag;
  way_oh_t                           rd_vbit;

  modport master (
    output req, we, vbit, flush, data, addr,
    input  rd_tag, rd_vbit
  );

  modport slave (
    input  req, we, vbit, flush, data, addr,
    output rd_tag, rd_vbit
  );

endinterface

// File: rtl/sargantana_itag_victim_sel.sv
// Refill victim way selection.
// Hit way first, then lowest invalid way, else round-robin.
module sargantana_itag_victim_sel
  import sargantana_icache_pkg::*;
(
  input  way_oh_t valid_i,
  input  way_oh_t hit_i,
  input  rr_t     rr_ptr_i,
  output way_oh_t victim_o,
  output logic    all_valid_o
);

  // Overwriting a hit way in place keeps tags unique per set.
  always_comb begin
    all_valid_o = &valid_i;
    victim_o    = '0;
    priority case (1'b1)
      (|hit_i):      victim_o = lowest_one(hit_i);
      (!all_valid_o): victim_o = lowest_one(~valid_i);
      default:       victim_o = way_oh_t'(1) << rr_ptr_i;
    endcase
  end

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Instruction tag memory sequencer/arbiter.
// Serves flush > refill > lookup, one op at a time.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              lkp_valid_i,
  output logic                              lkp_ready_o,
  input  set_t                              lkp_set_i,
  input  tag_t                              lkp_tag_i,
  output logic                              rsp_valid_o,
  output logic                              rsp_hit_o,
  output way_oh_t                           rsp_way_o,
  output logic                              rsp_multihit_o,
  input  logic                              rfl_valid_i,
  output logic                              rfl_ready_o,
  input  set_t                              rfl_set_i,
  input  tag_t                              rfl_tag_i,
  output logic                              rfl_done_o,
  output way_oh_t                           rfl_way_o,
  input  logic                              flush_i,
  output logic                              flush_done_o,
  output way_oh_t                           tag_req_o,
  output logic                              tag_we_o,
  output logic                              tag_vbit_o,
  output logic                              tag_flush_o,
  output tag_t                              tag_data_o,
  output set_t                              tag_addr_o,
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_i,
  input  way_oh_t                           tag_vbit_i
);

  itag_state_t state_q, state_d;
  set_t        set_q, set_d;
  tag_t        tag_q, tag_d;
  rr_t         rr_ptr_q, rr_ptr_d;
  logic        flush_pend_q, flush_pend_d;

  way_oh_t match;
  way_oh_t victim;
  logic    all_valid;
  logic    flush_req;

  // Compare each way's read data against the registered tag.
  always_comb begin
    match = '0;
    for (int i = 0; i < ICACHE_N_WAY; i++) begin
      match[i] = tag_vbit_i[i] &
        (tag_way_i[i*TAG_WIDHT +: TAG_WIDHT] == tag_q);
    end
  end

  sargantana_itag_victim_sel u_victim (
    .valid_i     (tag_vbit_i),
    .hit_i       (match),
    .rr_ptr_i    (rr_ptr_q),
    .victim_o    (victim),
    .all_valid_o (all_valid)
  );

  assign flush_req = flush_pend_q | flush_i;

  // Next state, request capture and memory port drive.
  always_comb begin
    state_d        = state_q;
    set_d          = set_q;
    tag_d          = tag_q;
    rr_ptr_d       = rr_ptr_q;
    flush_pend_d   = flush_pend_q;
    lkp_ready_o    = 1'b0;
    rfl_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_hit_o      = 1'b0;
    rsp_way_o      = '0;
    rsp_multihit_o = 1'b0;
    rfl_done_o     = 1'b0;
    rfl_way_o      = '0;
    flush_done_o   = 1'b0;
    tag_req_o      = '0;
    tag_we_o       = 1'b0;
    tag_vbit_o     = 1'b0;
    tag_flush_o    = 1'b0;
    tag_data_o     = '0;
    tag_addr_o     = '0;
    unique case (state_q)
      IDLE: begin
        rfl_ready_o = ~flush_req;
        lkp_ready_o = ~flush_req & ~rfl_valid_i;
        if (flush_req) begin
          state_d = FLUSH;
        end else if (rfl_valid_i) begin
          set_d      = rfl_set_i;
          tag_d      = rfl_tag_i;
          tag_req_o  = '1;
          tag_addr_o = rfl_set_i;
          state_d    = RFL_WR;
        end else if (lkp_valid_i) begin
          set_d      = lkp_set_i;
          tag_d      = lkp_tag_i;
          tag_req_o  = '1;
          tag_addr_o = lkp_set_i;
          state_d    = LKP_RSP;
        end
      end
      LKP_RSP: begin
        rsp_valid_o    = 1'b1;
        rsp_hit_o      = |match;
        rsp_way_o      = match;
        rsp_multihit_o = more_than_one(match);
        flush_pend_d   = flush_pend_q | flush_i;
        state_d        = IDLE;
      end
      RFL_WR: begin
        tag_req_o    = victim;
        tag_we_o     = 1'b1;
        tag_vbit_o   = 1'b1;
        tag_data_o   = tag_q;
        tag_addr_o   = set_q;
        rfl_done_o   = 1'b1;
        rfl_way_o    = victim;
        if (all_valid && !(|match)) begin
          rr_ptr_d = rr_ptr_q + rr_t'(1);
        end
        flush_pend_d = flush_pend_q | flush_i;
        state_d      = IDLE;
      end
      FLUSH: begin
        tag_flush_o  = 1'b1;
        flush_done_o = 1'b1;
        flush_pend_d = 1'b0;
        rr_ptr_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      lkp_ready_o    = 1'b0;
      rfl_ready_o    = 1'b0;
      rsp_valid_o    = 1'b0;
      rsp_hit_o      = 1'b0;
      rsp_way_o      = '0;
      rsp_multihit_o = 1'b0;
      rfl_done_o     = 1'b0;
      rfl_way_o      = '0;
      flush_done_o   = 1'b0;
      tag_req_o      = '0;
      tag_we_o       = 1'b0;
      tag_vbit_o     = 1'b0;
      tag_flush_o    = 1'b0;
      tag_data_o     = '0;
      tag_addr_o     = '0;
    end
  end

  // State and registered request fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      set_q        <= '0;
      tag_q        <= '0;
      rr_ptr_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule
